// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory-port arbiter.
// The optional round-robin mode is selected by MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

    localparam int MEM_ARB_ADDR_W = 32;
    localparam int MEM_ARB_LINE_W = 256;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

    // Busy state that serves the given requester id.
    function automatic arb_state_e busy_state_of(input logic req_id);
        if (req_id == REQ_D) begin
            return BUSY_D;
        end else begin
            return BUSY_I;
        end
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the instruction and data requesters.
// MEM_ARB_ROUND_ROBIN_EN adds a pointer input that breaks ties; otherwise data wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_enable_i,
    input  logic d_enable_i,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic rr_ptr_i,
`endif
    output logic valid_o,
    output logic pick_o
);

    // Tie-break only matters when both sides request together.
    always_comb begin
        valid_o = i_enable_i | d_enable_i;
        pick_o  = REQ_I;
        if (i_enable_i && d_enable_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            pick_o = rr_ptr_i;
`else
            pick_o = REQ_D;
`endif
        end else if (d_enable_i) begin
            pick_o = REQ_D;
        end else begin
            pick_o = REQ_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one off-chip memory port between the I-cache and D-cache controllers.
// Build with MEM_ARB_ROUND_ROBIN_EN for alternating grants; default is data-side priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = MEM_ARB_ADDR_W,
    parameter int LINE_W = MEM_ARB_LINE_W
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              i_enable_i,
    input  logic              i_write_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    input  logic [LINE_W-1:0] i_data_i,
    output logic [LINE_W-1:0] i_data_o,
    output logic              i_ack_o,

    input  logic              d_enable_i,
    input  logic              d_write_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [LINE_W-1:0] d_data_i,
    output logic [LINE_W-1:0] d_data_o,
    output logic              d_ack_o,

    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o
);

    arb_state_e        state_q;
    logic              mem_en_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [LINE_W-1:0] mem_data_q;

    logic              pick_valid_s;
    logic              pick_id_s;
    logic              lat_write_d;
    logic [ADDR_W-1:0] lat_addr_d;
    logic [LINE_W-1:0] lat_data_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              rr_ptr_q;
`endif

    mem_arb_pick u_pick (
        .i_enable_i (i_enable_i),
        .d_enable_i (d_enable_i),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .rr_ptr_i   (rr_ptr_q),
`endif
        .valid_o    (pick_valid_s),
        .pick_o     (pick_id_s)
    );

    // Transaction fields of whichever side wins the pick this cycle.
    always_comb begin
        lat_write_d = i_write_i;
        lat_addr_d  = i_addr_i;
        lat_data_d  = i_data_i;
        if (pick_id_s == REQ_D) begin
            lat_write_d = d_write_i;
            lat_addr_d  = d_addr_i;
            lat_data_d  = d_data_i;
        end else begin
            lat_write_d = i_write_i;
            lat_addr_d  = i_addr_i;
            lat_data_d  = i_data_i;
        end
    end

    // Arbitration FSM with the latched transaction and memory request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            mem_en_q    <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_data_q  <= {LINE_W{1'b0}};
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_ptr_q    <= REQ_D;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid_s) begin
                        state_q     <= busy_state_of(pick_id_s);
                        mem_en_q    <= 1'b1;
                        mem_write_q <= lat_write_d;
                        mem_addr_q  <= lat_addr_d;
                        mem_data_q  <= lat_data_d;
                    end else begin
                        state_q  <= IDLE;
                        mem_en_q <= 1'b0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mem_ack_i) begin
                        state_q  <= DONE;
                        mem_en_q <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        // The side that was not just served gets the next tie.
                        rr_ptr_q <= (state_q == BUSY_I) ? REQ_D : REQ_I;
`endif
                    end else begin
                        state_q  <= state_q;
                        mem_en_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q  <= IDLE;
                    mem_en_q <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    mem_en_q <= 1'b0;
                end
            endcase
        end
    end

    // Ack passes straight through, but only to the side that owns the port.
    always_comb begin
        i_ack_o = (state_q == BUSY_I) && mem_ack_i;
        d_ack_o = (state_q == BUSY_D) && mem_ack_i;
    end

    assign i_data_o     = mem_data_i;
    assign d_data_o     = mem_data_i;
    assign mem_enable_o = mem_en_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; expected grant order follows MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          i_enable_i = 1'b0;
    logic          i_write_i = 1'b0;
    logic [AW-1:0] i_addr_i = 32'h0;
    logic [LW-1:0] i_data_i = {LW{1'b0}};
    logic [LW-1:0] i_data_o;
    logic          i_ack_o;
    logic          d_enable_i = 1'b0;
    logic          d_write_i = 1'b0;
    logic [AW-1:0] d_addr_i = 32'h0;
    logic [LW-1:0] d_data_i = {LW{1'b0}};
    logic [LW-1:0] d_data_o;
    logic          d_ack_o;
    logic [LW-1:0] mem_data_i = {LW{1'b0}};
    logic          mem_ack_i = 1'b0;
    logic [LW-1:0] mem_data_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_enable_o;
    logic          mem_write_o;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [LW-1:0] line_a5;
    logic [LW-1:0] line_12;
    logic [LW-1:0] line_ff;
    logic          exp_d;
    int            hi_cnt;
    int            ack_cnt;

    mem_arbiter dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .i_enable_i   (i_enable_i),
        .i_write_i    (i_write_i),
        .i_addr_i     (i_addr_i),
        .i_data_i     (i_data_i),
        .i_data_o     (i_data_o),
        .i_ack_o      (i_ack_o),
        .d_enable_i   (d_enable_i),
        .d_write_i    (d_write_i),
        .d_addr_i     (d_addr_i),
        .d_data_i     (d_data_i),
        .d_data_o     (d_data_o),
        .d_ack_o      (d_ack_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i),
        .mem_data_o   (mem_data_o),
        .mem_addr_o   (mem_addr_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_en"},    256'(mem_enable_o), 256'(1'b0));
        chk({tag, "_wr"},    256'(mem_write_o),  256'(1'b0));
        chk({tag, "_addr"},  256'(mem_addr_o),   256'(32'h0));
        chk({tag, "_data"},  mem_data_o,         {LW{1'b0}});
        chk({tag, "_iack"},  256'(i_ack_o),      256'(1'b0));
        chk({tag, "_dack"},  256'(d_ack_o),      256'(1'b0));
    endtask

    initial begin
        line_a5 = {32{8'hA5}};
        line_12 = {8{32'h12345678}};
        line_ff = {LW{1'b1}};

        // Reset state
        step();
        step();
        chk_idle_outputs("rst");
        rst_i = 1'b0;

        // Single data-side read, memory acks in cycle 10
        d_enable_i = 1'b1;
        d_addr_i   = 32'h0000_0400;
        d_write_i  = 1'b0;
        hi_cnt  = 0;
        ack_cnt = 0;
        step();
        chk("t1_addr", 256'(mem_addr_o), 256'(32'h0000_0400));
        chk("t1_wr",   256'(mem_write_o), 256'(1'b0));
        for (int c = 1; c <= 9; c++) begin
            if (mem_enable_o) hi_cnt++;
            if (d_ack_o || i_ack_o) ack_cnt++;
            step();
        end
        if (mem_enable_o) hi_cnt++;
        mem_ack_i  = 1'b1;
        mem_data_i = line_a5;
        #1;
        if (d_ack_o) ack_cnt++;
        chk("t1_en_cycles", 256'(hi_cnt), 256'(10));
        chk("t1_dack",  256'(d_ack_o), 256'(1'b1));
        chk("t1_iack",  256'(i_ack_o), 256'(1'b0));
        chk("t1_ddata", d_data_o, line_a5);
        chk("t1_idata", i_data_o, line_a5);
        // Stale enable held into DONE, plus an ack there that must be ignored
        step();
        chk("t1_done_en", 256'(mem_enable_o), 256'(1'b0));
        chk("t1_done_dack", 256'(d_ack_o), 256'(1'b0));
        mem_ack_i  = 1'b0;
        d_enable_i = 1'b0;
        step();
        chk("t1_idle_en", 256'(mem_enable_o), 256'(1'b0));
        chk("t1_pulses", 256'(ack_cnt), 256'(1));

        // Write latch hold
        d_enable_i = 1'b1;
        d_write_i  = 1'b1;
        d_addr_i   = 32'h0000_0800;
        d_data_i   = line_12;
        step();
        chk("t3_en",   256'(mem_enable_o), 256'(1'b1));
        chk("t3_wr",   256'(mem_write_o),  256'(1'b1));
        d_data_i  = line_ff;
        d_addr_i  = 32'hDEAD_BEEF;
        d_write_i = 1'b0;
        step();
        step();
        step();
        chk("t3_hold_addr", 256'(mem_addr_o), 256'(32'h0000_0800));
        chk("t3_hold_data", mem_data_o, line_12);
        chk("t3_hold_wr",   256'(mem_write_o), 256'(1'b1));
        mem_ack_i = 1'b1;
        #1;
        chk("t3_dack", 256'(d_ack_o), 256'(1'b1));
        step();
        mem_ack_i  = 1'b0;
        d_enable_i = 1'b0;
        step();

        // Reset in cycle 5 of an instruction-side transaction
        i_enable_i = 1'b1;
        i_addr_i   = 32'h0000_0300;
        i_data_i   = line_a5;
        step();
        step();
        step();
        step();
        step();
        chk("t5_busy_en", 256'(mem_enable_o), 256'(1'b1));
        rst_i = 1'b1;
        step();
        rst_i      = 1'b0;
        i_enable_i = 1'b0;
        chk_idle_outputs("t5_rst");
        step();
        step();
        mem_ack_i = 1'b1;
        #1;
        chk("t5_late_iack", 256'(i_ack_o), 256'(1'b0));
        step();
        mem_ack_i = 1'b0;
        chk("t5_after_en", 256'(mem_enable_o), 256'(1'b0));

        // Simultaneous requests: data first, instruction granted at ack + 2
        i_addr_i   = 32'h0000_0100;
        d_addr_i   = 32'h0000_0200;
        i_enable_i = 1'b1;
        d_enable_i = 1'b1;
        step();
        chk("t2_first_addr", 256'(mem_addr_o), 256'(32'h0000_0200));
        mem_ack_i = 1'b1;
        #1;
        chk("t2_first_dack", 256'(d_ack_o), 256'(1'b1));
        chk("t2_first_iack", 256'(i_ack_o), 256'(1'b0));
        step();
        mem_ack_i  = 1'b0;
        d_enable_i = 1'b0;
        chk("t2_done_en", 256'(mem_enable_o), 256'(1'b0));
        step();
        chk("t2_idle_en", 256'(mem_enable_o), 256'(1'b0));
        step();
        chk("t2_second_en",   256'(mem_enable_o), 256'(1'b1));
        chk("t2_second_addr", 256'(mem_addr_o), 256'(32'h0000_0100));
        mem_ack_i = 1'b1;
        #1;
        chk("t2_second_iack", 256'(i_ack_o), 256'(1'b1));
        chk("t2_second_dack", 256'(d_ack_o), 256'(1'b0));
        step();
        mem_ack_i  = 1'b0;
        i_enable_i = 1'b0;
        step();

        // Both sides request continuously for four transactions
        i_enable_i = 1'b1;
        d_enable_i = 1'b1;
        for (int t = 0; t < 4; t++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_d = (t % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            step();
            chk($sformatf("t4_en_%0d", t), 256'(mem_enable_o), 256'(1'b1));
            chk($sformatf("t4_addr_%0d", t), 256'(mem_addr_o),
                256'(exp_d ? 32'h0000_0200 : 32'h0000_0100));
            mem_ack_i = 1'b1;
            #1;
            chk($sformatf("t4_dack_%0d", t), 256'(d_ack_o), 256'(exp_d));
            chk($sformatf("t4_iack_%0d", t), 256'(i_ack_o), 256'(!exp_d));
            step();
            mem_ack_i = 1'b0;
            step();
        end
        i_enable_i = 1'b0;
        d_enable_i = 1'b0;
        step();
        chk("t4_end_en", 256'(mem_enable_o), 256'(1'b0));

        // Spurious ack while idle, then confirm a fresh request is still granted
        mem_ack_i  = 1'b1;
        mem_data_i = line_12;
        #1;
        chk("t6_iack", 256'(i_ack_o), 256'(1'b0));
        chk("t6_dack", 256'(d_ack_o), 256'(1'b0));
        chk("t6_idata", i_data_o, line_12);
        step();
        chk("t6_en", 256'(mem_enable_o), 256'(1'b0));
        mem_ack_i  = 1'b0;
        d_enable_i = 1'b1;
        d_addr_i   = 32'h0000_0500;
        step();
        chk("t6_grant_en",   256'(mem_enable_o), 256'(1'b1));
        chk("t6_grant_addr", 256'(mem_addr_o), 256'(32'h0000_0500));
        mem_ack_i = 1'b1;
        #1;
        chk("t6_grant_dack", 256'(d_ack_o), 256'(1'b1));
        step();
        mem_ack_i  = 1'b0;
        d_enable_i = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
